// File: rtl/serial_byte_loader_if.sv
// ============================================================================
// Module      : serial_byte_loader_if
// Description : Serial line in, parallel byte/strobe bus out of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_byte_loader_if;
  logic       RxIn;
  logic [7:0] Q;
  logic       Ld;
  logic       FrameErr;
  logic       Busy;

  // master: the loader, driving Q/Ld into the downstream register
  modport master (
    input  RxIn,
    output Q,
    output Ld,
    output FrameErr,
    output Busy
  );

  // slave: the serial source and the register consuming Q/Ld
  modport slave (
    output RxIn,
    input  Q,
    input  Ld,
    input  FrameErr,
    input  Busy
  );
endinterface

`default_nettype wire

// File: rtl/serial_byte_loader.sv
// ============================================================================
// Module      : serial_byte_loader
// Description : 8N1 serial receiver presenting each good byte on Q with Ld.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_byte_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  wire logic              Clk,
  input  wire logic              Clr,
  serial_byte_loader_if.master   bus
);

  localparam int c_cw = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_half = c_cw'(CLKS_PER_BIT / 2);
  localparam logic [c_cw-1:0] c_last = c_cw'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_rx_s;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [7:0]      r_q;
  logic [7:0]      w_q_nxt;
  logic            r_ld;
  logic            w_ld_nxt;
  logic            r_ferr;
  logic            w_ferr_nxt;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_q       <= '0;
      r_ld      <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1   <= bus.RxIn;
      r_rx_s    <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_q       <= w_q_nxt;
      r_ld      <= w_ld_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_q_nxt     = r_q;
    w_ld_nxt    = 1'b0;
    w_ferr_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end

      // A start bit that is high again at mid-bit is only a glitch
      S_START: begin
        if (r_cnt == c_half) begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_cnt == c_last) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_cnt == c_last) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_q_nxt     = r_shift;
            w_ld_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // A break must end before another start bit can be recognised
      S_WAIT_HIGH: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.Q        = r_q;
  assign bus.Ld       = r_ld;
  assign bus.FrameErr = r_ferr;
  assign bus.Busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_byte_loader.sv
// ============================================================================
// Module      : tb_serial_byte_loader
// Description : Directed frames checked cycle by cycle against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_byte_loader;

  localparam int C   = 16;
  localparam int N   = 4096;
  localparam int LAT = 2 + C/2 + 9*C + 1;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  int checks   = 0;
  int failures = 0;
  int ld_cnt   = 0;
  int fe_cnt   = 0;
  int last_ld  = -1;

  // expected outputs per cycle index (cycle k = after the k-th rising edge)
  logic       exp_ld   [N];
  logic       exp_fe   [N];
  logic       exp_busy [N];
  logic [7:0] exp_q    [N];

  serial_byte_loader_if bus();

  serial_byte_loader #(.CLKS_PER_BIT(C)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus.master)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en && cyc < N) begin
      chk("Ld",       32'(bus.Ld),       32'(exp_ld[cyc]));
      chk("FrameErr", 32'(bus.FrameErr), 32'(exp_fe[cyc]));
      chk("Busy",     32'(bus.Busy),     32'(exp_busy[cyc]));
      chk("Q",        32'(bus.Q),        32'(exp_q[cyc]));
      if (bus.Ld === 1'b1) begin
        ld_cnt++;
        last_ld = cyc;
      end
      if (bus.FrameErr === 1'b1) fe_cnt++;
    end
  end

  // s = first edge that samples the start bit low
  task automatic plan_frame(input int s, input logic [7:0] d, input logic stopv);
    int l;
    l = s + LAT;
    for (int c = s + 2; c < l && c < N; c++) exp_busy[c] = 1'b1;
    if (l < N) begin
      if (stopv) begin
        exp_ld[l] = 1'b1;
        for (int c = l; c < N; c++) exp_q[c] = d;
      end else begin
        exp_fe[l] = 1'b1;
        for (int c = l; c < N; c++) exp_busy[c] = 1'b1;
      end
    end
  endtask

  task automatic clear_from(input int from);
    for (int c = from; c < N; c++) begin
      exp_ld[c]   = 1'b0;
      exp_fe[c]   = 1'b0;
      exp_busy[c] = 1'b0;
      exp_q[c]    = 8'h00;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.RxIn = 1'b1;
    wait_cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopv, output int s);
    s = cyc + 1;
    plan_frame(s, d, stopv);
    bus.RxIn = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      bus.RxIn = d[i];
      wait_cycles(C);
    end
    bus.RxIn = stopv;
    wait_cycles(C);
  endtask

  task automatic line_high();
    int h;
    bus.RxIn = 1'b1;
    h = cyc + 1;
    for (int c = h + 2; c < N; c++) exp_busy[c] = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    Clr      = 1'b1;
    bus.RxIn = 1'b1;
    clear_from(cyc);
    #1;
    chk("rst_Q",        32'(bus.Q),        32'h00);
    chk("rst_Ld",       32'(bus.Ld),       32'h0);
    chk("rst_FrameErr", 32'(bus.FrameErr), 32'h0);
    chk("rst_Busy",     32'(bus.Busy),     32'h0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Clr = 1'b0;
  endtask

  initial begin
    int s;
    int ld0;
    int fe0;
    for (int c = 0; c < N; c++) begin
      exp_ld[c] = 1'b0; exp_fe[c] = 1'b0; exp_busy[c] = 1'b0; exp_q[c] = 8'h00;
    end
    bus.RxIn = 1'b1;
    #1 Clr = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Clr    = 1'b0;
    chk_en = 1'b1;
    wait_cycles(4);

    // single frame and latency
    ld0 = ld_cnt;
    send_frame(8'hA5, 1'b1, s);
    idle(20);
    chk("a5_latency", 32'(last_ld - s), 32'd155);
    chk("a5_q",       32'(bus.Q),       32'hA5);
    chk("a5_ld_count", 32'(ld_cnt - ld0), 32'd1);
    chk("a5_no_ferr", 32'(fe_cnt),      32'd0);

    // asynchronous clear between edges
    do_reset();
    wait_cycles(5);

    // back-to-back frames
    ld0 = ld_cnt;
    send_frame(8'h00, 1'b1, s);
    send_frame(8'hFF, 1'b1, s);
    send_frame(8'h3C, 1'b1, s);
    idle(20);
    chk("b2b_ld_count", 32'(ld_cnt - ld0), 32'd3);
    chk("b2b_q",        32'(bus.Q),        32'h3C);

    // start glitch
    ld0 = ld_cnt;
    s = cyc + 1;
    for (int c = s + 2; c <= s + 2 + C/2; c++) exp_busy[c] = 1'b1;
    bus.RxIn = 1'b0;
    wait_cycles(3);
    idle(20);
    chk("glitch_ld_count", 32'(ld_cnt - ld0), 32'd0);
    chk("glitch_q",        32'(bus.Q),        32'h3C);
    send_frame(8'h5A, 1'b1, s);
    idle(20);
    chk("after_glitch_q", 32'(bus.Q), 32'h5A);

    // low stop bit followed by a held-low line
    ld0 = ld_cnt;
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b0, s);
    wait_cycles(50);
    line_high();
    wait_cycles(20);
    chk("ferr_count",    32'(fe_cnt - fe0), 32'd1);
    chk("ferr_no_ld",    32'(ld_cnt - ld0), 32'd0);
    chk("ferr_q_kept",   32'(bus.Q),        32'h5A);
    send_frame(8'h81, 1'b1, s);
    idle(20);
    chk("after_ferr_q", 32'(bus.Q), 32'h81);

    // clear during data bit 4
    ld0 = ld_cnt;
    s = cyc + 1;
    plan_frame(s, 8'h77, 1'b1);
    bus.RxIn = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 4; i++) begin
      bus.RxIn = 1'(8'h77 >> i);
      wait_cycles(C);
    end
    bus.RxIn = 1'b1;
    wait_cycles(C/2);
    do_reset();
    wait_cycles(10);
    chk("abort_no_ld", 32'(ld_cnt - ld0), 32'd0);
    chk("abort_q",     32'(bus.Q),        32'h00);
    send_frame(8'h12, 1'b1, s);
    idle(20);
    chk("after_abort_ld_count", 32'(ld_cnt - ld0), 32'd1);
    chk("after_abort_q",        32'(bus.Q),        32'h12);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
